tlp_req_seg_fifo: RTL

TLP_REQ_SEG_FIFO -- requirements
Module: tlp_req_seg_fifo

---
 rtl/tlp_req_seg_fifo.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/tlp_req_seg_fifo.sv
// Segmented TLP request FIFO with per-segment sop/eop framing checks.
// Define TLP_FIFO_STORE_FWD_EN to hold beats until a complete TLP is stored.
module tlp_req_seg_fifo #(
   parameter int SEG_COUNT    = 1,
   parameter int DATA_WIDTH   = 256,
   parameter int HDR_WIDTH    = 128,
   parameter int DEPTH        = 16,
   parameter int AFULL_THRESH = 12
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_WIDTH-1:0]          in_tlp_data,
   input  logic [SEG_COUNT*HDR_WIDTH-1:0] in_tlp_hdr,
   input  logic [SEG_COUNT-1:0]           in_tlp_valid,
   input  logic [SEG_COUNT-1:0]           in_tlp_sop,
   input  logic [SEG_COUNT-1:0]           in_tlp_eop,
   output logic                           in_tlp_ready,
   output logic [DATA_WIDTH-1:0]          out_tlp_data,
   output logic [SEG_COUNT*HDR_WIDTH-1:0] out_tlp_hdr,
   output logic [SEG_COUNT-1:0]           out_tlp_valid,
   output logic [SEG_COUNT-1:0]           out_tlp_sop,
   output logic [SEG_COUNT-1:0]           out_tlp_eop,
   input  logic                           out_tlp_ready,
   output logic [$clog2(DEPTH):0]         level,
   output logic                           almost_full,
   output logic                           err_proto,
   output logic [7:0]                     err_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int HW = SEG_COUNT * HDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
   logic [HW-1:0]         mem_hdr_q  [DEPTH];
   logic [SEG_COUNT-1:0]  mem_vld_q  [DEPTH];
   logic [SEG_COUNT-1:0]  mem_sop_q  [DEPTH];
   logic [SEG_COUNT-1:0]  mem_eop_q  [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          rdy_q, rdy_d;
   logic          af_q, af_d;
   logic          in_frame_q, in_frame_d;
   logic          err_q, err_d;
   logic [7:0]    err_cnt_q, err_cnt_d;
   logic          push, pop, present;
   logic          beat_err, frame_scan;

   assign push = (|in_tlp_valid) && rdy_q;
   assign pop  = present && out_tlp_ready;

`ifdef TLP_FIFO_STORE_FWD_EN
   logic [LW-1:0] eop_cnt_q, eop_cnt_d;
   logic          in_has_eop, head_has_eop;

   assign in_has_eop   = |(in_tlp_valid & in_tlp_eop);
   assign head_has_eop = |(mem_vld_q[rd_ptr_q] & mem_eop_q[rd_ptr_q]);
   // A full FIFO is released even without an eop so oversized frames drain.
   assign present = (level_q != '0) &&
                    ((eop_cnt_q != '0) || (level_q == LW'(DEPTH)));

   always_comb begin
      eop_cnt_d = eop_cnt_q;
      if (push && in_has_eop) eop_cnt_d = eop_cnt_d + LW'(1);
      if (pop && head_has_eop) eop_cnt_d = eop_cnt_d - LW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) eop_cnt_q <= '0;
      else      eop_cnt_q <= eop_cnt_d;
   end
`else
   assign present = (level_q != '0);
`endif

   always_comb begin
      frame_scan = in_frame_q;
      beat_err   = 1'b0;
      for (int i = 0; i < SEG_COUNT; i++) begin
         if (in_tlp_valid[i]) begin
            if (in_tlp_sop[i] == frame_scan) beat_err = 1'b1;
            if (in_tlp_sop[i]) frame_scan = 1'b1;
            if (in_tlp_eop[i]) frame_scan = 1'b0;
         end
      end
   end

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      rdy_d      = (level_d != LW'(DEPTH));
      af_d       = (level_d >= LW'(AFULL_THRESH));
      in_frame_d = push ? frame_scan : in_frame_q;
      err_d      = push && beat_err;
      err_cnt_d  = err_cnt_q;
      if (err_d && (err_cnt_q != 8'hff)) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         rdy_q      <= 1'b0;
         af_q       <= 1'b0;
         in_frame_q <= 1'b0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         rdy_q      <= rdy_d;
         af_q       <= af_d;
         in_frame_q <= in_frame_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // Storage needs no reset; its contents are qualified by level.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data_q[wr_ptr_q] <= in_tlp_data;
         mem_hdr_q[wr_ptr_q]  <= in_tlp_hdr;
         mem_vld_q[wr_ptr_q]  <= in_tlp_valid;
         mem_sop_q[wr_ptr_q]  <= in_tlp_sop;
         mem_eop_q[wr_ptr_q]  <= in_tlp_eop;
      end
   end

   assign in_tlp_ready  = rdy_q;
   assign out_tlp_data  = mem_data_q[rd_ptr_q];
   assign out_tlp_hdr   = mem_hdr_q[rd_ptr_q];
   assign out_tlp_valid = present ? mem_vld_q[rd_ptr_q] : '0;
   assign out_tlp_sop   = present ? mem_sop_q[rd_ptr_q] : '0;
   assign out_tlp_eop   = present ? mem_eop_q[rd_ptr_q] : '0;
   assign level         = level_q;
   assign almost_full   = af_q;
   assign err_proto     = err_q;
   assign err_count     = err_cnt_q;

endmodule
